systolic_seq_ctrl: RTL and testbench

//   Sequencer for the 16x8 register-file datapath. Loads A/B operand bytes

---
 rtl/systolic_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// ----------------------------------------------------------------------------
// systolic_seq_ctrl
//
// Sequencer for a small register-file datapath. Operand bytes for A and B
// arrive on a valid/ready byte stream and are written into the register file.
// A single MAC then computes C = A*B (unsigned, NxN), reading both operands
// through the file's two combinational read ports, one product per cycle.
// Each finished C element is saturated to DATA_W bits and written back. Once
// all of C is stored, C is streamed out on a valid/ready result port.
//
// Register-file map (row-major): A at 0, B at N*N, C at 2*N*N.
//
// Ports
//   clk         clock
//   rst_n       synchronous active-low reset
//   ena         clock enable; 0 freezes all state and suppresses rf_we
//   start       begin a job (acted on in IDLE only)
//   cmd_valid   operand byte valid
//   cmd_data    operand byte (A then B, row-major)
//   cmd_ready   operand byte accepted when cmd_valid & cmd_ready
//   rf_we       register-file write enable
//   rf_waddr    register-file write address
//   rf_wdata    register-file write data
//   rf_raddr_a  register-file read port A address
//   rf_raddr_b  register-file read port B address
//   rf_rdata_a  register-file read port A data (combinational)
//   rf_rdata_b  register-file read port B data (combinational)
//   res_valid   result byte valid
//   res_data    result byte (C row-major)
//   res_ready   result consumer ready
//   busy        high in every state except IDLE
//   done        one-cycle pulse on the last result transfer
// ----------------------------------------------------------------------------
module systolic_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int N      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic              cmd_valid,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              cmd_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr_a,
    output logic [ADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    input  logic              res_ready,
    output logic              busy,
    output logic              done
);

    // Loop counter width; at least one bit so N=1 still elaborates.
    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    // Sum of N products of two DATA_W values cannot exceed this width.
    localparam int ACC_W = 2 * DATA_W + $clog2(N);

    localparam logic [ADDR_W-1:0] N_A       = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] B_BASE    = ADDR_W'(N * N);
    localparam logic [ADDR_W-1:0] C_BASE    = ADDR_W'(2 * N * N);
    localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(2 * N * N - 1);
    localparam logic [ADDR_W-1:0] OUT_LAST  = ADDR_W'(N * N - 1);
    localparam logic [CW-1:0]     DIM_LAST  = CW'(N - 1);
    localparam logic [ACC_W-1:0]  SAT_MAX   = {{(ACC_W - DATA_W){1'b0}}, {DATA_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_WRITE   = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;    // load byte index / output element index
    logic [CW-1:0]     i_q, i_d;        // C row
    logic [CW-1:0]     j_q, j_d;        // C column
    logic [CW-1:0]     k_q, k_d;        // dot-product term
    logic [ACC_W-1:0]  acc_q, acc_d;

    logic [ACC_W-1:0]  prod;
    logic              last_out;

    assign prod     = ACC_W'(rf_rdata_a) * ACC_W'(rf_rdata_b);
    assign last_out = (idx_q == OUT_LAST);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;

        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    // cmd_valid is deliberately not looked at here.
                    if (start) begin
                        state_d = S_LOAD;
                        idx_d   = '0;
                    end
                end

                S_LOAD: begin
                    if (cmd_valid) begin
                        if (idx_q == LOAD_LAST) begin
                            state_d = S_COMPUTE;
                            idx_d   = '0;
                            i_d     = '0;
                            j_d     = '0;
                            k_d     = '0;
                        end else begin
                            idx_d = idx_q + ADDR_W'(1);
                        end
                    end
                end

                S_COMPUTE: begin
                    // First term of each dot product restarts the accumulator.
                    acc_d = ((k_q == '0) ? '0 : acc_q) + prod;
                    if (k_q == DIM_LAST) begin
                        state_d = S_WRITE;
                    end else begin
                        k_d = k_q + CW'(1);
                    end
                end

                S_WRITE: begin
                    k_d     = '0;
                    state_d = S_COMPUTE;
                    if (j_q == DIM_LAST) begin
                        j_d = '0;
                        if (i_q == DIM_LAST) begin
                            i_d     = '0;
                            idx_d   = '0;
                            state_d = S_OUT;
                        end else begin
                            i_d = i_q + CW'(1);
                        end
                    end else begin
                        j_d = j_q + CW'(1);
                    end
                end

                S_OUT: begin
                    if (res_ready) begin
                        if (last_out) begin
                            state_d = S_IDLE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + ADDR_W'(1);
                        end
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // Handshake-qualifying outputs (cmd_ready, res_valid, done) are gated by
    // ena so that no byte can change hands while the sequencer is frozen;
    // addresses and data are purely state-derived and therefore hold.
    // ------------------------------------------------------------------------
    always_comb begin
        cmd_ready  = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        rf_raddr_a = '0;
        rf_raddr_b = '0;
        res_valid  = 1'b0;
        res_data   = '0;
        done       = 1'b0;
        busy       = (state_q != S_IDLE);

        case (state_q)
            S_LOAD: begin
                cmd_ready = ena;
                rf_we     = ena & cmd_valid;
                rf_waddr  = idx_q;
                rf_wdata  = cmd_data;
            end

            S_COMPUTE: begin
                rf_raddr_a = ADDR_W'(i_q) * N_A + ADDR_W'(k_q);
                rf_raddr_b = B_BASE + ADDR_W'(k_q) * N_A + ADDR_W'(j_q);
            end

            S_WRITE: begin
                rf_we    = ena;
                rf_waddr = C_BASE + ADDR_W'(i_q) * N_A + ADDR_W'(j_q);
                rf_wdata = (acc_q > SAT_MAX) ? {DATA_W{1'b1}} : acc_q[DATA_W-1:0];
            end

            S_OUT: begin
                rf_raddr_a = C_BASE + idx_q;
                res_valid  = ena;
                res_data   = rf_rdata_a;
                done       = ena & res_ready & last_out;
            end

            default: ;
        endcase
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
module tb_systolic_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       rf_we;
    logic [3:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [3:0] rf_raddr_a;
    logic [3:0] rf_raddr_b;
    logic [7:0] rf_rdata_a;
    logic [7:0] rf_rdata_b;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_ready;
    logic       busy;
    logic       done;

    systolic_seq_ctrl #(.DATA_W(8), .ADDR_W(4), .N(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16x8 register file: synchronous write, combinational reads
    logic [7:0] rf_mem [16];
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    end
    assign rf_rdata_a = rf_mem[rf_raddr_a];
    assign rf_rdata_b = rf_mem[rf_raddr_b];

    // Operand streams: byte n at bits [8n+7:8n]; A row-major then B row-major
    localparam logic [63:0] T1_OPS = 64'h08_07_06_05_04_03_02_01; // A=[1,2;3,4] B=[5,6;7,8]
    localparam logic [63:0] T2_OPS = 64'hC8_C8_C8_C8_C8_C8_C8_C8; // all 200
    // Hand-computed C: byte n = C element n (row-major)
    localparam logic [31:0] T1_RES = 32'h32_2B_16_13;             // 19,22,43,50
    localparam logic [31:0] T2_RES = 32'hFF_FF_FF_FF;             // 80000 saturates to 255

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int lat_cnt = 0;
    bit lat_armed = 0;
    bit prev_stall = 0;
    logic [7:0] prev_data = '0;

    logic [7:0]  exp_res [$];
    logic [11:0] exp_wr  [$];   // {addr, data} of expected C write-backs

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] r);
        for (int n = 0; n < 4; n++) begin
            exp_res.push_back(r[8*n +: 8]);
            exp_wr.push_back({4'(8 + n), r[8*n +: 8]});
        end
    endtask

    // Pulse start in IDLE together with a junk operand byte that must be ignored
    task automatic start_job();
        start     = 1'b1;
        cmd_valid = 1'b1;
        cmd_data  = 8'd99;
        tick();
        start     = 1'b0;
        cmd_valid = 1'b0;
    endtask

    // Returns just after the edge that accepted the last byte (first COMPUTE cycle)
    task automatic load_bytes(input logic [63:0] ops, input int gap);
        bit acc;
        int waited;
        for (int n = 0; n < 8; n++) begin
            cmd_valid = 1'b1;
            cmd_data  = ops[8*n +: 8];
            acc       = 1'b0;
            waited    = 0;
            while (!acc && waited < 20) begin
                @(negedge clk);
                acc = cmd_ready;
                @(posedge clk);
                #1;
                waited++;
            end
            check("load_accept", acc, 1);
            cmd_valid = 1'b0;
            if (n < 7) begin
                for (int g = 0; g < gap; g++) tick();
            end
        end
    endtask

    task automatic wait_done(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < max_cyc && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else      check("busy_in_job", busy, 1);
            @(posedge clk);
            #1;
        end
        check("done_seen", seen, 1);
    endtask

    task automatic wait_res_valid(input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < max_cyc && !seen; n++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("res_valid_seen", seen, 1);
    endtask

    // Monitor / scoreboard, sampling mid-cycle
    always @(negedge clk) begin
        logic [7:0]  e;
        logic [11:0] w;
        if (rst_n) begin
            if (ena && start && !busy) begin
                lat_cnt   = 0;
                lat_armed = 1'b1;
            end else if (ena && busy && !cmd_ready && !res_valid) begin
                lat_cnt++;
            end
            if (res_valid && lat_armed) begin
                check("compute_latency", lat_cnt, 12);
                lat_armed = 1'b0;
            end

            if (prev_stall && ena) begin
                check("stall_valid_held", res_valid, 1);
                check("stall_data_stable", res_data, prev_data);
            end

            if (res_valid && res_ready) begin
                check("res_expected", exp_res.size() != 0, 1);
                if (exp_res.size() != 0) begin
                    e = exp_res.pop_front();
                    check("res_data", res_data, e);
                end
            end

            if (done) begin
                done_cnt++;
                check("done_on_transfer", res_valid && res_ready, 1);
                check("done_on_last_byte", exp_res.size(), 0);
            end

            if (rf_we) begin
                if (rf_waddr >= 4'd8) begin
                    check("c_write_expected", exp_wr.size() != 0, 1);
                    if (exp_wr.size() != 0) begin
                        w = exp_wr.pop_front();
                        check("c_write_addr_data", {rf_waddr, rf_wdata}, w);
                    end
                end else begin
                    check("load_write_handshake", cmd_valid && cmd_ready, 1);
                end
            end

            prev_stall = res_valid && !res_ready;
            prev_data  = res_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        start     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        res_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // T1: basic multiply
        push_exp(T1_RES);
        start_job();
        load_bytes(T1_OPS, 0);
        wait_done(100);
        $display("T1 basic job complete, done_cnt=%0d", done_cnt);
        check("t1_rf_c00", rf_mem[8], 19);
        check("t1_rf_c01", rf_mem[9], 22);
        check("t1_rf_c10", rf_mem[10], 43);
        check("t1_rf_c11", rf_mem[11], 50);

        // T2: saturation, started the cycle after done
        push_exp(T2_RES);
        start_job();
        load_bytes(T2_OPS, 0);
        wait_done(100);
        $display("T2 saturation job complete, done_cnt=%0d", done_cnt);

        // T3: result back-pressure mid-stream
        res_ready = 1'b0;
        push_exp(T1_RES);
        start_job();
        load_bytes(T1_OPS, 0);
        wait_res_valid(40);
        res_ready = 1'b1;
        tick();
        tick();
        res_ready = 1'b0;
        repeat (5) tick();
        res_ready = 1'b1;
        wait_done(20);
        $display("T3 stalled output job complete, done_cnt=%0d", done_cnt);

        // T4: gapped load, start pulsed during COMPUTE
        push_exp(T1_RES);
        start_job();
        load_bytes(T1_OPS, 1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100);
        $display("T4 gapped load job complete, done_cnt=%0d", done_cnt);

        // T5: reset during COMPUTE k=1, then rerun
        start_job();
        load_bytes(T1_OPS, 0);
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_res_valid", res_valid, 0);
        check("abort_rf_we", rf_we, 0);
        check("abort_cmd_ready", cmd_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(T1_RES);
        start_job();
        load_bytes(T1_OPS, 0);
        wait_done(100);
        $display("T5 abort and rerun complete, done_cnt=%0d", done_cnt);

        // T6: ena low in WRITE and in OUT
        res_ready = 1'b0;
        push_exp(T1_RES);
        start_job();
        load_bytes(T1_OPS, 0);
        tick();
        tick();
        ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("freeze_write_rf_we", rf_we, 0);
            check("freeze_write_busy", busy, 1);
            check("freeze_write_waddr", rf_waddr, 8);
            @(posedge clk);
            #1;
        end
        ena = 1'b1;
        wait_res_valid(40);
        res_ready = 1'b1;
        tick();
        ena       = 1'b0;
        res_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("freeze_out_rf_we", rf_we, 0);
            check("freeze_out_busy", busy, 1);
            @(posedge clk);
            #1;
        end
        ena       = 1'b1;
        res_ready = 1'b1;
        wait_done(20);
        $display("T6 enable freeze job complete, done_cnt=%0d", done_cnt);

        repeat (3) tick();
        check("res_queue_drained", exp_res.size(), 0);
        check("write_queue_drained", exp_wr.size(), 0);
        check("done_pulse_count", done_cnt, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
